// File: rtl/flash_erase_seq.sv
// SPI NOR sector-erase sequencer: WREN, SE <addr>, then RDSR polling until WIP clears
// or the poll limit is reached. SPI mode 0, 4 sys_clk per bit, all outputs registered.
module flash_erase_seq #(
  parameter int unsigned T_CSH    = 32,
  parameter logic [15:0] POLL_MAX = 16'd50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic        miso,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi
);

  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    WREN  = 7'b0000010,
    GAP_A = 7'b0000100,
    SE    = 7'b0001000,
    GAP_B = 7'b0010000,
    RDSR  = 7'b0100000,
    GAP_C = 7'b1000000
  } state_t;

  localparam logic [31:0] WREN_FRAME = 32'h0600_0000;
  localparam logic [31:0] RDSR_FRAME = 32'h0500_0000;
  localparam logic [15:0] GAP_LAST   = 16'(T_CSH - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;
  logic [15:0] frame_len;
  logic [15:0] poll_cnt;
  logic [23:0] addr_q;
  logic [31:0] tx_sr;
  logic [31:0] se_frame;
  logic [7:0]  rx_sr;

  assign cnt_nx   = cnt + 16'd1;
  assign se_frame = {8'hD8, addr_q};

  always_comb begin
    case (state)
      WREN:    frame_len = 16'd32;
      SE:      frame_len = 16'd128;
      RDSR:    frame_len = 16'd64;
      default: frame_len = '0;
    endcase
  end

  // cnt is the frame/gap cycle currently on the pins; pin values are computed
  // one edge ahead from cnt_nx so they stay registered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      poll_cnt <= '0;
      addr_q   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done && !err) begin
            state    <= WREN;
            busy     <= 1'b1;
            addr_q   <= addr;
            poll_cnt <= '0;
            cnt      <= '0;
            cs_n     <= 1'b0;
            sck      <= 1'b0;
            mosi     <= WREN_FRAME[31];
            tx_sr    <= {WREN_FRAME[30:0], 1'b0};
          end
        end
        WREN, SE, RDSR: begin
          if (cnt_nx == frame_len) begin
            cs_n <= 1'b1;
            sck  <= 1'b0;
            mosi <= 1'b0;
            cnt  <= '0;
            case (state)
              WREN:    state <= GAP_A;
              SE:      state <= GAP_B;
              default: begin
                state <= GAP_C;
                if (poll_cnt != '1) poll_cnt <= poll_cnt + 16'd1;
              end
            endcase
          end else begin
            cnt <= cnt_nx;
            sck <= cnt_nx[1];
            if (cnt_nx[1:0] == 2'd0) begin
              mosi  <= tx_sr[31];
              tx_sr <= {tx_sr[30:0], 1'b0};
            end
            if (cnt_nx[1:0] == 2'd2) rx_sr <= {rx_sr[6:0], miso};
          end
        end
        GAP_A, GAP_B, GAP_C: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (state == GAP_A) begin
              state <= SE;
              cs_n  <= 1'b0;
              mosi  <= se_frame[31];
              tx_sr <= {se_frame[30:0], 1'b0};
            end else if (state == GAP_B || (rx_sr[0] && poll_cnt != POLL_MAX)) begin
              state <= RDSR;
              cs_n  <= 1'b0;
              mosi  <= RDSR_FRAME[31];
              tx_sr <= {RDSR_FRAME[30:0], 1'b0};
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= !rx_sr[0];
              err   <= rx_sr[0];
            end
          end else begin
            cnt <= cnt_nx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_erase_seq.sv
// Self-checking bench for flash_erase_seq: behavioural flash model, SPI frame decoder
// and a per-sequence expected frame list derived from the polling rules.
module tb_flash_erase_seq;

  localparam int unsigned T_CSH    = 32;
  localparam logic [15:0] POLL_MAX = 16'd4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic [23:0] addr;
  logic        miso;
  logic        busy, done, err, sck, cs_n, mosi;

  flash_erase_seq #(.T_CSH(T_CSH), .POLL_MAX(POLL_MAX)) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .addr     (addr),
    .miso     (miso),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .sck      (sck),
    .cs_n     (cs_n),
    .mosi     (mosi)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flash model: reports WIP=1 for the first wip_polls RDSR frames, then WIP=0.
  int         wip_polls = 0;
  int         rdsr_seen = 0;
  int         fl_bits   = 0;
  logic [7:0] fl_op     = '0;
  logic [7:0] fl_stat   = '0;

  always @(negedge cs_n) begin
    fl_bits = 0;
    fl_op   = '0;
    miso    = 1'($urandom);
  end

  always @(posedge sck) begin
    if (!cs_n) begin
      if (fl_bits < 8) fl_op = {fl_op[6:0], mosi};
      fl_bits++;
    end
  end

  always @(negedge sck) begin
    if (!cs_n) begin
      if (fl_bits == 8 && fl_op == 8'h05) begin
        fl_stat = {7'($urandom), 1'(rdsr_seen < wip_polls)};
        rdsr_seen++;
      end
      if (fl_op == 8'h05 && fl_bits >= 8 && fl_bits < 16) miso = fl_stat[15 - fl_bits];
      else miso = 1'($urandom);
    end
  end

  // SPI monitor: decodes frames and checks bit timing and cs_n gaps.
  typedef struct {
    int          nbytes;
    logic [31:0] data;
  } frame_t;

  frame_t      obs_q[$];
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  bit          in_frame = 1'b0, first_frame = 1'b1;
  int          fcyc = 0, last_rise = 0, nbits = 0, gap_cyc = 0;
  int          done_cnt = 0, err_cnt = 0;
  logic [31:0] shreg = '0;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (done || err) begin
        check("done_err_excl", 32'(done & err), 32'd0);
        done_cnt += int'(done);
        err_cnt  += int'(err);
        check("end_gap", 32'(gap_cyc), T_CSH);
        check("busy_at_end", 32'(busy), 32'd0);
        check("idle_lines", 32'({cs_n, sck, mosi}), 32'b100);
      end
      if (prev_cs && !cs_n) begin
        if (!first_frame) check("cs_gap", 32'(gap_cyc), T_CSH);
        first_frame = 1'b0;
        in_frame    = 1'b1;
        fcyc        = 0;
        nbits       = 0;
        last_rise   = 0;
        shreg       = '0;
        check("sck_at_cs_fall", 32'(sck), 32'd0);
      end else if (in_frame) begin
        fcyc++;
        if (!prev_sck && sck) begin
          if (nbits == 0) check("first_rise", 32'(fcyc), 32'd2);
          else check("sck_period", 32'(fcyc - last_rise), 32'd4);
          check("mosi_stable", 32'(mosi), 32'(prev_mosi));
          shreg     = {shreg[30:0], mosi};
          nbits++;
          last_rise = fcyc;
        end
        if (cs_n) begin
          check("sck_at_cs_rise", 32'(sck), 32'd0);
          check("frame_len", 32'(fcyc), 32'(nbits * 4));
          obs_q.push_back('{nbits / 8, shreg});
          in_frame = 1'b0;
          gap_cyc  = 1;
        end
      end else begin
        gap_cyc++;
      end
    end
    prev_cs   = cs_n;
    prev_sck  = sck;
    prev_mosi = mosi;
  end

  task automatic run_seq(input logic [23:0] a, input int n_wip, input bit extra_start,
                         input bit start_on_done);
    int     polls;
    bit     exp_done;
    bit     finished;
    frame_t exp_q[$];
    wip_polls   = n_wip;
    rdsr_seen   = 0;
    obs_q.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    first_frame = 1'b1;
    exp_done    = (n_wip < int'(POLL_MAX));
    polls       = exp_done ? n_wip + 1 : int'(POLL_MAX);
    exp_q.push_back('{1, 32'h06});
    exp_q.push_back('{4, {8'hD8, a}});
    repeat (polls) exp_q.push_back('{2, 32'h0500});

    @(negedge sys_clk);
    addr  = a;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    addr  = 24'($urandom);
    check("busy_rise", 32'(busy), 32'd1);
    check("cs_fall", 32'(cs_n), 32'd0);

    finished = 1'b0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge sys_clk);
      start = 1'b0;
      if (done || err) begin
        finished = 1'b1;
        if (start_on_done) start = 1'b1;
      end else if (extra_start && c == 100) begin
        start = 1'b1;
        addr  = 24'($urandom);
      end
    end
    check("seq_finished", 32'(finished), 32'd1);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (2 * T_CSH + 40) @(negedge sys_clk);

    check("done_cnt", 32'(done_cnt), 32'(exp_done));
    check("err_cnt", 32'(err_cnt), 32'(!exp_done));
    check("busy_after", 32'(busy), 32'd0);
    check("frame_cnt", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("frame%0d_bytes", i), 32'(obs_q[i].nbytes), 32'(exp_q[i].nbytes));
      check($sformatf("frame%0d_data", i), obs_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    sys_rst_n = 1'b1;
    start     = 1'b0;
    addr      = '0;
    miso      = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_sck", 32'(sck), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done_err", 32'({done, err}), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    run_seq(24'h012345, 0, 1'b0, 1'b0);
    run_seq(24'hA5A5A5, 3, 1'b0, 1'b0);   // WIP clears exactly on the last allowed poll
    run_seq(24'h00FFFF, 100, 1'b0, 1'b0); // WIP stuck: poll limit
    run_seq(24'h5A0F3C, 0, 1'b1, 1'b0);   // second start during SE frame
    run_seq(24'h777777, 1, 1'b0, 1'b1);   // start coincident with done
    run_seq(24'h888888, 10, 1'b0, 1'b1);  // start coincident with err

    // Reset during byte 2 of the SE frame
    first_frame = 1'b1;
    @(negedge sys_clk);
    addr  = 24'hABCDEF;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (130) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    done_cnt = 0;
    err_cnt  = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2 * T_CSH + 200) @(negedge sys_clk);
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_no_err", 32'(err_cnt), 32'd0);
    check("rst_idle_cs", 32'(cs_n), 32'd1);
    run_seq(24'h0F1E2D, 1, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++)
      run_seq(24'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
